// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the execute-stage multiply/divide sequencer.
package muldiv_seq_ctrl_pkg;

    localparam logic [4:0] OPC_RTYPE   = 5'b00000;
    localparam logic [4:0] ALU_MUL     = 5'b00110;
    localparam logic [4:0] ALU_DIV     = 5'b00111;

    localparam logic [4:0] RSTATUS_REG = 5'd30;
    localparam logic [2:0] RSTATUS_MUL = 3'd4;
    localparam logic [2:0] RSTATUS_DIV = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == OPC_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// X-stage / multdiv-unit / writeback bundle seen by the sequencer.
interface muldiv_seq_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        opcode_x;
    logic [4:0]        aluop_x;
    logic [4:0]        rd_x;
    logic              flush;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              md_ready;
    logic              md_exception;
    logic [DATA_W-1:0] md_result;
    logic              md_ctrl_mult;
    logic              md_ctrl_div;
    logic [DATA_W-1:0] md_op_a;
    logic [DATA_W-1:0] md_op_b;
    logic              stall;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output opcode_x, aluop_x, rd_x, flush, operand_a, operand_b,
               md_ready, md_exception, md_result,
        input  md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b,
               stall, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  opcode_x, aluop_x, rd_x, flush, operand_a, operand_b,
               md_ready, md_exception, md_result,
        output md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b,
               stall, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/muldiv_seq_ctrl_md_watchdog.sv
// Saturating BUSY-cycle counter with terminal flag; only built when MULDIV_TIMEOUT_EN is defined.
`ifdef MULDIV_TIMEOUT_EN
module md_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th BUSY cycle
    assign tc_o = en_i && (cnt_q == TC_VAL);
endmodule
`endif

// File: rtl/muldiv_seq_ctrl.sv
// Execute-stage sequencer for the multicycle multiply/divide unit: issue, stall, one-cycle writeback.
// Define MULDIV_TIMEOUT_EN to add the BUSY watchdog (forces an exception writeback after TIMEOUT_CYCLES).
//
// state | meaning
// IDLE  | waiting for an unflushed MUL/DIV in X
// ISSUE | start pulse to the unit, operands held
// BUSY  | waiting for md_ready (or flush / watchdog)
// DONE  | writeback cycle, stall released
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    muldiv_seq_ctrl_if.slave bus
);

    md_state_e         state_q, state_d;
    logic              is_div_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] op_a_q, op_b_q;

    logic              mult_q, mult_d;
    logic              div_q, div_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic start, start_div, abort, finish, timeout, md_exc;

    assign start     = (state_q == ST_IDLE) && is_md_op(bus.opcode_x, bus.aluop_x) && !bus.flush;
    assign start_div = (bus.aluop_x == ALU_DIV);
    assign abort     = ((state_q == ST_ISSUE) || (state_q == ST_BUSY)) && bus.flush;
    assign finish    = (state_q == ST_BUSY) && !bus.flush && (bus.md_ready || timeout);
    // A real result wins over a watchdog expiry in the same cycle
    assign md_exc    = bus.md_ready ? bus.md_exception : timeout;

`ifdef MULDIV_TIMEOUT_EN
    md_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_md_watchdog (
        .clock  (clock),
        .reset_n(reset_n),
        .clr_i  (start),
        .en_i   (state_q == ST_BUSY),
        .tc_o   (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: state_d = abort ? ST_IDLE : ST_BUSY;
            ST_BUSY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.stall  = 1'b0;
        mult_d     = 1'b0;
        div_d      = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                bus.stall = start;
                mult_d    = start && !start_div;
                div_d     = start && start_div;
            end
            ST_ISSUE, ST_BUSY: bus.stall = !bus.flush;
            default: bus.stall = 1'b0;
        endcase
        if (finish) begin
            if (md_exc) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = RSTATUS_REG;
                wb_data_d  = DATA_W'(is_div_q ? RSTATUS_DIV : RSTATUS_MUL);
            end else if (rd_q != 5'd0) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = bus.md_result;
            end
        end
        // Keep the pipeline free while reset holds the FSM in IDLE
        bus.stall = bus.stall && reset_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_div_q   <= 1'b0;
            rd_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            if (start) begin
                is_div_q <= start_div;
                rd_q     <= bus.rd_x;
                op_a_q   <= bus.operand_a;
                op_b_q   <= bus.operand_b;
            end
            mult_q     <= mult_d;
            div_q      <= div_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.md_ctrl_mult = mult_q;
    assign bus.md_ctrl_div  = div_q;
    assign bus.md_op_a      = op_a_q;
    assign bus.md_op_b      = op_b_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;

endmodule
